// File: rtl/ispm_port_arbiter.sv
// Round-robin arbiter sharing one scratchpad BRAM port among NREQ valid/ready requesters.
// Bounded bursts per owner; responses return one cycle after acceptance to the issuer.
module ispm_port_arbiter #(
  parameter int DATA      = 72,
  parameter int ADDR      = 10,
  parameter int NREQ      = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*ADDR-1:0] req_addr,
  input  logic [NREQ*DATA-1:0] req_wdata,
  output logic [NREQ-1:0]      resp_valid,
  output logic [DATA-1:0]      resp_rdata,
  output logic                 bram_wr,
  output logic [ADDR-1:0]      bram_addr,
  output logic [DATA-1:0]      bram_din,
  input  logic [DATA-1:0]      bram_dout
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = $clog2(MAX_BURST + 1);
  localparam int NPAD = 2 ** IW;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  logic [IW-1:0]   cur;
  logic [CW-1:0]   cnt;
  logic            rsp_vld;
  logic [IW-1:0]   rsp_idx;

  logic [NPAD-1:0] vld_pad;
  logic [IW-1:0]   cand;
  logic            cand_ok;
  logic            others;
  logic            acc;
  logic            sel_wr;
  logic [ADDR-1:0] sel_addr;
  logic [DATA-1:0] sel_wdata;

  // Padding keeps every IW-bit index in range when NREQ is not a power of two.
  always_comb begin
    vld_pad = '0;
    vld_pad[NREQ-1:0] = req_valid;
  end

  always_comb begin
    others = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if ((IW'(i) != cur) && req_valid[i]) others = 1'b1;
    end
  end

  // Scan from the farthest slot toward cur+1 so the nearest valid requester wins.
  always_comb begin
    logic [IW-1:0] idx;
    cand    = cur;
    cand_ok = 1'b0;
    idx     = '0;
    if (vld_pad[cur] && ((cnt < CNT_MAX) || !others)) begin
      cand_ok = 1'b1;
    end else begin
      for (int k = NREQ - 1; k >= 1; k--) begin
        idx = IW'((int'(cur) + k) % NREQ);
        if (vld_pad[idx]) begin
          cand    = idx;
          cand_ok = 1'b1;
        end
      end
    end
  end

  // With no candidate cand equals cur, so the BRAM sees the owner's fields as a harmless read.
  always_comb begin
    sel_wr    = req_wr[0];
    sel_addr  = req_addr[0 +: ADDR];
    sel_wdata = req_wdata[0 +: DATA];
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == cand) begin
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[i*ADDR +: ADDR];
        sel_wdata = req_wdata[i*DATA +: DATA];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && cand_ok) begin
      for (int i = 0; i < NREQ; i++) begin
        if (IW'(i) == cand) req_ready[i] = 1'b1;
      end
    end
  end

  assign acc       = |(req_valid & req_ready);
  assign bram_wr   = acc & sel_wr;
  assign bram_addr = sel_addr;
  assign bram_din  = sel_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= '0;
      cnt     <= '0;
      rsp_vld <= 1'b0;
      rsp_idx <= '0;
    end else begin
      rsp_vld <= acc;
      rsp_idx <= cand;
      if (acc) begin
        if (cand == cur) begin
          if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
        end else begin
          cur <= cand;
          cnt <= CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    if (rst_n && rsp_vld) begin
      for (int i = 0; i < NREQ; i++) begin
        if (IW'(i) == rsp_idx) resp_valid[i] = 1'b1;
      end
    end
  end

  assign resp_rdata = bram_dout;

endmodule

// File: tb/tb_ispm_port_arbiter.sv
// Bench for ispm_port_arbiter: BRAM model, vector table, hand sequences and a randomized run
// against a behavioural arbitration/memory model.
module tb_ispm_port_arbiter;

  localparam int DATA = 72;
  localparam int ADDR = 10;
  localparam int NR   = 2;
  localparam int MB   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]      req_valid, req_ready, req_wr, resp_valid;
  logic [NR*ADDR-1:0] req_addr;
  logic [NR*DATA-1:0] req_wdata;
  logic [DATA-1:0]    resp_rdata, bram_din, bram_dout;
  logic               bram_wr;
  logic [ADDR-1:0]    bram_addr;

  logic [2:0]          v3, r3, wr3, rv3;
  logic [3*ADDR-1:0]   a3;
  logic [3*DATA-1:0]   wd3;
  logic [DATA-1:0]     rd3, din3, dout3;
  logic                bwr3;
  logic [ADDR-1:0]     ba3;

  ispm_port_arbiter #(.DATA(DATA), .ADDR(ADDR), .NREQ(NR), .MAX_BURST(MB)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .bram_wr(bram_wr), .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
  );

  ispm_port_arbiter #(.DATA(DATA), .ADDR(ADDR), .NREQ(3), .MAX_BURST(MB)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v3), .req_ready(r3), .req_wr(wr3),
    .req_addr(a3), .req_wdata(wd3),
    .resp_valid(rv3), .resp_rdata(rd3),
    .bram_wr(bwr3), .bram_addr(ba3), .bram_din(din3), .bram_dout(dout3)
  );

  // BRAM: registered read, write-through, preload port used only while in reset.
  logic [DATA-1:0] mem [0:1023];
  logic            pl_en = 1'b0;
  logic [3:0]      pl_addr = '0;
  logic [DATA-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bram_wr) begin
      mem[bram_addr] <= bram_din;
      bram_dout      <= bram_din;
    end else begin
      bram_dout <= mem[bram_addr];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [DATA-1:0] act, input logic [DATA-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner, length of its current run, pending response and memory image.
  int              m_cur, m_run, m_rsp;
  logic [DATA-1:0] m_rsp_data;
  logic [DATA-1:0] ref_mem [16];

  task automatic model_reset();
    m_cur = 0;
    m_run = 0;
    m_rsp = -1;
  endtask

  function automatic int pick(input logic [NR-1:0] v);
    int n_other = 0;
    for (int i = 0; i < NR; i++) if (i != m_cur && v[i]) n_other++;
    if (v[m_cur] && (m_run < MB || n_other == 0)) return m_cur;
    for (int k = 1; k < NR; k++) if (v[(m_cur + k) % NR]) return (m_cur + k) % NR;
    return -1;
  endfunction

  // Called at a falling edge; drives one cycle, checks against the model, returns at the next falling edge.
  task automatic cycle(input logic [NR-1:0] v, input logic [NR-1:0] w,
                       input logic [ADDR-1:0] a0, input logic [ADDR-1:0] a1,
                       input logic [DATA-1:0] d0, input logic [DATA-1:0] d1,
                       output logic [NR-1:0] g_rdy, output logic [NR-1:0] g_rsp,
                       output logic [DATA-1:0] g_rd);
    int c, s;
    logic [NR-1:0]   exp_rdy, exp_rsp;
    logic            exp_wr;
    logic [ADDR-1:0] aa;
    logic [DATA-1:0] dd;
    req_valid = v; req_wr = w; req_addr = {a1, a0}; req_wdata = {d1, d0};
    #1;
    g_rdy = req_ready; g_rsp = resp_valid; g_rd = resp_rdata;
    c = pick(v);
    exp_rdy = '0;
    exp_wr  = 1'b0;
    if (c >= 0) begin
      exp_rdy[c] = 1'b1;
      exp_wr     = w[c];
    end
    s = (c >= 0) ? c : m_cur;
    check("ready", DATA'(req_ready), DATA'(exp_rdy));
    check("bram_wr", DATA'(bram_wr), DATA'(exp_wr));
    check("bram_addr", DATA'(bram_addr), DATA'((s == 0) ? a0 : a1));
    exp_rsp = '0;
    if (m_rsp >= 0) exp_rsp[m_rsp] = 1'b1;
    check("resp_valid", DATA'(resp_valid), DATA'(exp_rsp));
    if (m_rsp >= 0) check("resp_rdata", resp_rdata, m_rsp_data);
    m_rsp = c;
    if (c >= 0) begin
      aa = (c == 0) ? a0 : a1;
      dd = (c == 0) ? d0 : d1;
      m_rsp_data = w[c] ? dd : ref_mem[aa[3:0]];
      if (w[c]) ref_mem[aa[3:0]] = dd;
      if (c == m_cur) m_run = (m_run < MB) ? m_run + 1 : MB;
      else begin
        m_cur = c;
        m_run = 1;
      end
    end else begin
      m_run = 0;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]      v, w;
    logic [ADDR-1:0] a0, a1;
    logic [DATA-1:0] d1;
    logic [1:0]      rdy, rsp;
    bit              chk_d;
    logic [DATA-1:0] rdata;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [NR-1:0]   g_rdy, g_rsp;
    logic [DATA-1:0] g_rd;
    logic [DATA-1:0] d;

    req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    v3 = '0; wr3 = '0; a3 = '0; wd3 = '0; dout3 = '0;
    model_reset();

    tbl.push_back('{2'b01, 2'b00, 10'd5, 10'd0, '0, 2'b01, 2'b00, 1'b0, '0});
    tbl.push_back('{2'b00, 2'b00, 10'd5, 10'd0, '0, 2'b00, 2'b01, 1'b1, 72'hAB});
    tbl.push_back('{2'b11, 2'b00, 10'd1, 10'd2, '0, 2'b01, 2'b00, 1'b0, '0});
    tbl.push_back('{2'b11, 2'b00, 10'd1, 10'd2, '0, 2'b01, 2'b01, 1'b0, '0});
    tbl.push_back('{2'b11, 2'b00, 10'd1, 10'd2, '0, 2'b10, 2'b01, 1'b0, '0});
    tbl.push_back('{2'b11, 2'b00, 10'd1, 10'd2, '0, 2'b10, 2'b10, 1'b0, '0});
    tbl.push_back('{2'b11, 2'b00, 10'd1, 10'd2, '0, 2'b01, 2'b10, 1'b0, '0});
    tbl.push_back('{2'b11, 2'b00, 10'd1, 10'd2, '0, 2'b01, 2'b01, 1'b0, '0});
    for (int i = 0; i < 10; i++)
      tbl.push_back('{2'b01, 2'b00, 10'd3, 10'd4, '0, 2'b01, 2'b01, 1'b0, '0});
    tbl.push_back('{2'b00, 2'b00, 10'd3, 10'd4, '0, 2'b00, 2'b01, 1'b0, '0});
    tbl.push_back('{2'b10, 2'b10, 10'd0, 10'd9, 72'h1234, 2'b10, 2'b00, 1'b0, '0});
    tbl.push_back('{2'b01, 2'b00, 10'd9, 10'd0, '0, 2'b01, 2'b10, 1'b1, 72'h1234});
    tbl.push_back('{2'b00, 2'b00, 10'd9, 10'd0, '0, 2'b00, 2'b01, 1'b1, 72'h1234});

    // Outputs held low during reset even with requests and writes pending.
    req_valid = 2'b11; req_wr = 2'b11; v3 = 3'b111;
    #3;
    check("rst ready", DATA'(req_ready), '0);
    check("rst resp_valid", DATA'(resp_valid), '0);
    check("rst bram_wr", DATA'(bram_wr), '0);
    check("rst ready3", DATA'(r3), '0);
    req_valid = '0; req_wr = '0; v3 = '0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      d = (i == 5) ? DATA'(72'hAB) : DATA'(i * 3 + 100);
      pl_en = 1'b1; pl_addr = 4'(i); pl_data = d;
      ref_mem[i] = d;
    end
    @(negedge clk);
    pl_en = 1'b0;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].w, tbl[i].a0, tbl[i].a1, '0, tbl[i].d1, g_rdy, g_rsp, g_rd);
      check($sformatf("vec%0d ready", i), DATA'(g_rdy), DATA'(tbl[i].rdy));
      check($sformatf("vec%0d resp_valid", i), DATA'(g_rsp), DATA'(tbl[i].rsp));
      if (tbl[i].chk_d) check($sformatf("vec%0d rdata", i), g_rd, tbl[i].rdata);
    end

    // Reset while the owner-1 read is in flight.
    for (int i = 0; i < 3; i++) cycle(2'b11, 2'b00, 10'd1, 10'd2, '0, '0, g_rdy, g_rsp, g_rd);
    check("inflight resp_valid", DATA'(resp_valid), DATA'(2'b10));
    req_valid = 2'b11; req_wr = 2'b11;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst resp_valid", DATA'(resp_valid), '0);
    check("midrst bram_wr", DATA'(bram_wr), '0);
    check("midrst ready", DATA'(req_ready), '0);
    @(negedge clk);
    req_valid = '0; req_wr = '0;
    rst_n = 1'b1;
    model_reset();
    cycle(2'b11, 2'b00, 10'd1, 10'd2, '0, '0, g_rdy, g_rsp, g_rd);
    check("post-rst first grant", DATA'(g_rdy), DATA'(2'b01));

    // Three requesters: scan order from cur=0 reaches req1 before req2.
    v3 = 3'b110;
    #1;
    check("n3 grant0", DATA'(r3), DATA'(3'b010));
    cycle(2'b00, 2'b00, 10'd0, 10'd0, '0, '0, g_rdy, g_rsp, g_rd);
    #1;
    check("n3 grant1", DATA'(r3), DATA'(3'b010));
    check("n3 resp", DATA'(rv3), DATA'(3'b010));
    cycle(2'b00, 2'b00, 10'd0, 10'd0, '0, '0, g_rdy, g_rsp, g_rd);
    #1;
    check("n3 grant2", DATA'(r3), DATA'(3'b100));
    cycle(2'b00, 2'b00, 10'd0, 10'd0, '0, '0, g_rdy, g_rsp, g_rd);
    v3 = '0;

    for (int n = 0; n < 400; n++) begin
      cycle(NR'($urandom_range(0, 3)), NR'($urandom_range(0, 3)),
            ADDR'($urandom_range(0, 15)), ADDR'($urandom_range(0, 15)),
            DATA'({$urandom(), $urandom(), $urandom()}),
            DATA'({$urandom(), $urandom(), $urandom()}),
            g_rdy, g_rsp, g_rd);
    end
    cycle(2'b00, 2'b00, 10'd0, 10'd0, '0, '0, g_rdy, g_rsp, g_rd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
